// File: rtl/e_mdu_pkg.sv
// Shared md_op encodings, result type and decode helper for the execute-stage multiply/divide unit.
package e_mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic is_mult_div(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Purely combinational 64-bit multiply/divide result for one md_op and operand pair.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  i_md_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output md_result_t  o_result
);

    logic [31:0] w_div_b;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;

    // A zero divisor is replaced by one; the owner discards that result anyway.
    assign w_div_b  = (i_b == 32'd0) ? 32'd1 : i_b;
    assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign w_abs_a = i_a[31] ? (32'd0 - i_a) : i_a;
    assign w_abs_b = w_div_b[31] ? (32'd0 - w_div_b) : w_div_b;
    assign w_q_mag = w_abs_a / w_abs_b;
    assign w_r_mag = w_abs_a % w_abs_b;
    assign w_q_s   = (i_a[31] ^ w_div_b[31]) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s   = i_a[31] ? (32'd0 - w_r_mag) : w_r_mag;
    assign w_q_u   = i_a / w_div_b;
    assign w_r_u   = i_a % w_div_b;

    always_comb begin
        o_result = '0;
        case (i_md_op)
            MD_MULT:  o_result = w_prod_s;
            MD_MULTU: o_result = w_prod_u;
            MD_DIV:   o_result = {w_r_s, w_q_s};
            MD_DIVU:  o_result = {w_r_u, w_q_u};
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: multi-cycle busy window, delayed HI/LO commit, MTHI/MTLO writes.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_rs_data,
    input  logic [31:0] E_rt_data,
    input  logic [3:0]  md_op,
    input  logic        start,
    output logic        E_busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_tmp_hi;
    logic [31:0]      r_tmp_lo;
    logic             r_div_zero;

    logic             w_busy_q;
    logic             w_launch;
    logic             w_is_div;
    md_result_t       w_result;

    assign w_busy_q = (r_cnt != '0);
    assign w_launch = start && !w_busy_q && is_mult_div(md_op);
    assign w_is_div = (md_op == MD_DIV) || (md_op == MD_DIVU);
    assign E_busy   = start | w_busy_q;
    assign E_HI     = r_hi;
    assign E_LO     = r_lo;

    e_mdu_calc u_calc (
        .i_md_op  (md_op),
        .i_a      (E_rs_data),
        .i_b      (E_rt_data),
        .o_result (w_result)
    );

    // While busy everything else is ignored; a divide by zero still waits out its window but never commits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_tmp_hi   <= '0;
            r_tmp_lo   <= '0;
            r_div_zero <= 1'b0;
        end else if (w_busy_q) begin
            if (r_cnt == CNT_ONE) begin
                r_cnt <= '0;
                if (!r_div_zero) begin
                    r_hi <= r_tmp_hi;
                    r_lo <= r_tmp_lo;
                end
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end else if (w_launch) begin
            r_tmp_hi   <= w_result.hi;
            r_tmp_lo   <= w_result.lo;
            r_div_zero <= w_is_div && (E_rt_data == 32'd0);
            r_cnt      <= w_is_div ? CNT_DIV : CNT_MULT;
        end else if (!start) begin
            if (md_op == MD_MTHI) begin
                r_hi <= E_rs_data;
            end else if (md_op == MD_MTLO) begin
                r_lo <= E_rs_data;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Randomized plus directed bench for e_mdu, checked every cycle against an arithmetic reference model.
module tb_e_mdu;
    import e_mdu_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [31:0] E_rs_data;
    logic [31:0] E_rt_data;
    logic [3:0]  md_op;
    logic        start;
    logic        E_busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkEn     = 0;

    // Reference model state: architectural HI/LO plus the one outstanding op and the edge it lands on.
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    bit          mPending = 0;
    longint      mCommitEdge = 0;
    bit          mDivZero = 0;
    logic [63:0] mRes = '0;
    longint      edgeNum = 0;

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_rs_data (E_rs_data),
        .E_rt_data (E_rt_data),
        .md_op     (md_op),
        .start     (start),
        .E_busy    (E_busy),
        .E_HI      (E_HI),
        .E_LO      (E_LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isMd(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // {HI,LO} computed from plain integer arithmetic on 64-bit values.
    function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        res = '0;
        if (op == MD_MULT) begin
            res = sa * sb;
        end else if (op == MD_MULTU) begin
            res = ua * ub;
        end else if (op == MD_DIV && b != 0) begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end else if (op == MD_DIVU && b != 0) begin
            q   = longint'(ua / ub);
            r   = longint'(ua % ub);
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            mHi      = '0;
            mLo      = '0;
            mPending = 0;
        end else if (mPending) begin
            if (edgeNum == mCommitEdge) begin
                if (!mDivZero) begin
                    mHi = mRes[63:32];
                    mLo = mRes[31:0];
                end
                mPending = 0;
            end
        end else if (start) begin
            if (isMd(md_op)) begin
                mPending    = 1;
                mRes        = refResult(md_op, E_rs_data, E_rt_data);
                mDivZero    = (md_op == MD_DIV || md_op == MD_DIVU) && (E_rt_data == 0);
                mCommitEdge = edgeNum + ((md_op == MD_DIV || md_op == MD_DIVU) ? DIV_N : MULT_N);
            end
        end else if (md_op == MD_MTHI) begin
            mHi = E_rs_data;
        end else if (md_op == MD_MTLO) begin
            mLo = E_rs_data;
        end
        edgeNum++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("cmp_busy", {31'd0, E_busy}, {31'd0, start | mPending});
            checkOutput("cmp_hi", E_HI, mHi);
            checkOutput("cmp_lo", E_LO, mLo);
        end
    end

    task automatic applyStimulus(input logic [3:0] op, input logic st, input logic [31:0] a, input logic [31:0] b);
        md_op     = op;
        start     = st;
        E_rs_data = a;
        E_rt_data = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(MD_NONE, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic randomCycles(input int n, input bit allowReset);
        logic [3:0]  op;
        logic        st;
        logic [31:0] a;
        logic [31:0] b;
        for (int k = 0; k < n; k++) begin
            case ($urandom_range(0, 15))
                0, 1:    op = MD_NONE;
                2, 3:    op = MD_MULT;
                4, 5:    op = MD_MULTU;
                6, 7:    op = MD_DIV;
                8, 9:    op = MD_DIVU;
                10, 11:  op = MD_MTHI;
                12, 13:  op = MD_MTLO;
                default: op = 4'($urandom_range(7, 15));
            endcase
            st    = isMd(op) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            a     = randOperand();
            b     = randOperand();
            reset = allowReset ? ($urandom_range(0, 99) != 0) : 1'b1;
            applyStimulus(op, st, a, b);
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idleCycles(2);
        reset   = 1'b1;
        checkEn = 1;

        randomCycles(20, 0);
        reset = 1'b0;
        idleCycles(1);
        reset = 1'b1;
        checkOutput("reset_hi", E_HI, 32'd0);
        checkOutput("reset_lo", E_LO, 32'd0);
        checkOutput("reset_busy", {31'd0, E_busy}, 32'd0);

        applyStimulus(MD_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3);
        idleCycles(4);
        checkOutput("mult_busy_last", {31'd0, E_busy}, 32'd1);
        idleCycles(1);
        checkOutput("mult_busy_done", {31'd0, E_busy}, 32'd0);
        checkOutput("mult_hi", E_HI, 32'hFFFF_FFFF);
        checkOutput("mult_lo", E_LO, 32'hFFFF_FFFA);

        applyStimulus(MD_MULTU, 1'b1, 32'hFFFF_FFFE, 32'd3);
        idleCycles(5);
        checkOutput("multu_hi", E_HI, 32'h0000_0002);
        checkOutput("multu_lo", E_LO, 32'hFFFF_FFFA);

        applyStimulus(MD_DIVU, 1'b1, 32'd7, 32'd2);
        applyStimulus(MD_MULT, 1'b1, 32'd5, 32'd5);
        applyStimulus(MD_MTHI, 1'b0, 32'h0000_ABCD, 32'd0);
        idleCycles(7);
        checkOutput("divu_busy_last", {31'd0, E_busy}, 32'd1);
        checkOutput("divu_hi_held", E_HI, 32'h0000_0002);
        idleCycles(1);
        checkOutput("divu_hi", E_HI, 32'd1);
        checkOutput("divu_lo", E_LO, 32'd3);

        applyStimulus(MD_MTLO, 1'b0, 32'h0000_0055, 32'd0);
        checkOutput("mtlo_lo", E_LO, 32'h0000_0055);
        checkOutput("mtlo_hi", E_HI, 32'd1);

        applyStimulus(MD_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2);
        idleCycles(10);
        checkOutput("div_neg_lo", E_LO, 32'hFFFF_FFFD);
        checkOutput("div_neg_hi", E_HI, 32'hFFFF_FFFF);

        applyStimulus(MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        idleCycles(10);
        checkOutput("div_ovf_lo", E_LO, 32'h8000_0000);
        checkOutput("div_ovf_hi", E_HI, 32'd0);

        applyStimulus(MD_MTHI, 1'b0, 32'h0000_0011, 32'd0);
        applyStimulus(MD_MTLO, 1'b0, 32'h0000_0022, 32'd0);
        applyStimulus(MD_DIV, 1'b1, 32'd5, 32'd0);
        idleCycles(9);
        checkOutput("divz_busy_last", {31'd0, E_busy}, 32'd1);
        idleCycles(1);
        checkOutput("divz_busy_done", {31'd0, E_busy}, 32'd0);
        checkOutput("divz_hi", E_HI, 32'h0000_0011);
        checkOutput("divz_lo", E_LO, 32'h0000_0022);

        applyStimulus(MD_MULT, 1'b1, 32'd9, 32'd9);
        idleCycles(2);
        reset = 1'b0;
        idleCycles(1);
        reset = 1'b1;
        checkOutput("rst_mid_busy", {31'd0, E_busy}, 32'd0);
        checkOutput("rst_mid_hi", E_HI, 32'd0);
        idleCycles(3);
        checkOutput("rst_nocommit_lo", E_LO, 32'd0);
        applyStimulus(MD_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3);
        idleCycles(5);
        checkOutput("rst_after_hi", E_HI, 32'hFFFF_FFFF);
        checkOutput("rst_after_lo", E_LO, 32'hFFFF_FFFA);

        randomCycles(3000, 1);
        idleCycles(12);

        checkEn = 0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
